// File: rtl/divisor_secuencial_nb_pkg.sv
// Shared types and width helpers for the sequential restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CALCULO  = 2'd1,
    FIN      = 2'd2
  } estado_div_t;

  // Iteration counter must hold the value N itself.
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divisor_secuencial_nb_if.sv
// Handshake and operand/result bundle between the control unit and the divider.
interface divisor_secuencial_nb_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic         listo;
  logic         valido;
  logic [N-1:0] cociente;
  logic [N-1:0] residuo;
  logic         div_cero;

  modport master (
    output start, dividendo, divisor,
    input  listo, valido, cociente, residuo, div_cero
  );

  modport slave (
    input  start, dividendo, divisor,
    output listo, valido, cociente, residuo, div_cero
  );
endinterface

// File: rtl/divisor_secuencial_nb_restador.sv
// W-bit subtractor d = a - b - ci; co is the borrow out (1 when a < b + ci).
module restador_nb #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] d,
  output logic         co
);

  logic [W:0] diff_s;

  // Extra top bit of the widened difference is the borrow.
  always_comb begin
    diff_s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
  end

  assign d  = diff_s[W-1:0];
  assign co = diff_s[W];

endmodule

// File: rtl/divisor_secuencial_nb.sv
// Multi-cycle unsigned restoring divider: one shared subtractor, N iterations,
// start/listo/valido handshake, divide-by-zero detection.
module divisor_secuencial_nb
  import divisor_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  divisor_secuencial_nb_if.slave  bus
);

  localparam int CW = CNT_W(N);

  estado_div_t   estado_r;
  logic [N-1:0]  r_r;
  logic [N-1:0]  q_r;
  logic [N-1:0]  divisor_r;
  logic [CW-1:0] cnt_r;

  logic          listo_r;
  logic          valido_r;
  logic [N-1:0]  cociente_r;
  logic [N-1:0]  residuo_r;
  logic          div_cero_r;

  logic [N:0]    t_s;
  logic [N:0]    d_s;
  logic          borrow_s;
  logic [N-1:0]  r_next_s;
  logic [N-1:0]  q_next_s;
  logic          unused_s;

  assign t_s = {r_r, q_r[N-1]};

  restador_nb #(
    .W (N + 1)
  ) u_restador (
    .a  (t_s),
    .b  ({1'b0, divisor_r}),
    .ci (1'b0),
    .d  (d_s),
    .co (borrow_s)
  );

  // The top difference bit is always zero when no borrow occurs.
  assign unused_s = d_s[N];

  // One restoring step: keep the difference unless the subtraction borrowed.
  always_comb begin
    r_next_s = t_s[N-1:0];
    q_next_s = {q_r[N-2:0], 1'b0};
    if (borrow_s) begin
      r_next_s = t_s[N-1:0];
      q_next_s = {q_r[N-2:0], 1'b0};
    end else begin
      r_next_s = d_s[N-1:0];
      q_next_s = {q_r[N-2:0], 1'b1};
    end
  end

  // Control FSM, iteration counter, shift registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r   <= INACTIVO;
      r_r        <= {N{1'b0}};
      q_r        <= {N{1'b0}};
      divisor_r  <= {N{1'b0}};
      cnt_r      <= {CW{1'b0}};
      listo_r    <= 1'b1;
      valido_r   <= 1'b0;
      cociente_r <= {N{1'b0}};
      residuo_r  <= {N{1'b0}};
      div_cero_r <= 1'b0;
    end else begin
      case (estado_r)
        INACTIVO: begin
          valido_r <= 1'b0;
          if (bus.start) begin
            listo_r <= 1'b0;
            if (bus.divisor == {N{1'b0}}) begin
              estado_r   <= FIN;
              valido_r   <= 1'b1;
              cociente_r <= {N{1'b1}};
              residuo_r  <= bus.dividendo;
              div_cero_r <= 1'b1;
            end else begin
              estado_r  <= CALCULO;
              divisor_r <= bus.divisor;
              r_r       <= {N{1'b0}};
              q_r       <= bus.dividendo;
              cnt_r     <= CW'(N);
            end
          end else begin
            listo_r <= 1'b1;
          end
        end
        CALCULO: begin
          r_r   <= r_next_s;
          q_r   <= q_next_s;
          cnt_r <= cnt_r - CW'(1);
          // Results are captured from the final step so they are valid in FIN.
          if (cnt_r == CW'(1)) begin
            estado_r   <= FIN;
            valido_r   <= 1'b1;
            cociente_r <= q_next_s;
            residuo_r  <= r_next_s;
            div_cero_r <= 1'b0;
          end else begin
            estado_r <= CALCULO;
          end
        end
        FIN: begin
          estado_r <= INACTIVO;
          valido_r <= 1'b0;
          listo_r  <= 1'b1;
        end
        default: begin
          estado_r <= INACTIVO;
          valido_r <= 1'b0;
          listo_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.listo    = listo_r;
  assign bus.valido   = valido_r;
  assign bus.cociente = cociente_r;
  assign bus.residuo  = residuo_r;
  assign bus.div_cero = div_cero_r;

endmodule

// File: tb/tb_divisor_secuencial_nb.sv
// Directed and random checks of the sequential divider at N=8.
module tb_divisor_secuencial_nb;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  int errors;
  int checks;
  int proto_err;
  logic valido_prev;

  divisor_secuencial_nb_if #(.N(N)) bus ();

  divisor_secuencial_nb #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs [12];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valido && bus.listo) proto_err <= proto_err + 1;
      if (bus.valido && valido_prev) proto_err <= proto_err + 1;
      valido_prev <= bus.valido;
    end else begin
      valido_prev <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!bus.listo && g < 50) begin
      @(negedge clk);
      g++;
    end
    bus.start     = 1'b1;
    bus.dividendo = a;
    bus.divisor   = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.valido) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int low_cnt;
    int v_cnt;
    logic [7:0] cq, cr, ra, rb, eq, er;

    errors = 0; checks = 0; proto_err = 0; valido_prev = 1'b0;
    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
    vecs[1]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9};
    vecs[2]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vecs[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vecs[4]  = '{8'd37,  8'd0,   8'hFF,  8'd37,  1'b1, 1};
    vecs[5]  = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9};
    vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    vecs[7]  = '{8'd200, 8'd16,  8'd12,  8'd8,   1'b0, 9};
    vecs[8]  = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 9};
    vecs[9]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9};
    vecs[10] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};
    vecs[11] = '{8'd254, 8'd15,  8'd16,  8'd14,  1'b0, 9};

    rst_n = 1'b0;
    bus.start = 1'b0; bus.dividendo = 8'd0; bus.divisor = 8'd0;
    @(negedge clk);
    chk("reset_listo", 32'(bus.listo), 32'd1);
    chk("reset_valido", 32'(bus.valido), 32'd0);
    chk("reset_cociente", 32'(bus.cociente), 32'd0);
    chk("reset_residuo", 32'(bus.residuo), 32'd0);
    chk("reset_div_cero", 32'(bus.div_cero), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_cociente", i), 32'(bus.cociente), 32'(vecs[i].q));
      chk($sformatf("vec%0d_residuo", i), 32'(bus.residuo), 32'(vecs[i].r));
      chk($sformatf("vec%0d_div_cero", i), 32'(bus.div_cero), 32'(vecs[i].z));
    end

    // Results must hold after FIN.
    repeat (3) @(negedge clk);
    chk("hold_cociente", 32'(bus.cociente), 32'd16);
    chk("hold_residuo", 32'(bus.residuo), 32'd14);
    chk("hold_valido", 32'(bus.valido), 32'd0);
    chk("hold_listo", 32'(bus.listo), 32'd1);

    // start held high with changing operands throughout a 50/6 operation.
    low_cnt = 0; v_cnt = 0; cq = 8'd0; cr = 8'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividendo = 8'd50; bus.divisor = 8'd6;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      #1;
      bus.dividendo = 8'($urandom_range(0, 255));
      bus.divisor   = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (!bus.listo) low_cnt++;
      if (bus.valido) begin
        v_cnt++;
        cq = bus.cociente;
        cr = bus.residuo;
        @(posedge clk);
        #1 bus.start = 1'b0;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    chk("busy_fin_start_ignored", 32'(bus.listo), 32'd1);
    @(negedge clk);
    chk("busy_no_extra_valido", 32'(bus.valido), 32'd0);
    chk("busy_listo_low_cycles", 32'(low_cnt), 32'(N + 1));
    chk("busy_valido_count", 32'(v_cnt), 32'd1);
    chk("busy_cociente", 32'(cq), 32'd8);
    chk("busy_residuo", 32'(cr), 32'd2);

    // Asynchronous reset during CALCULO.
    @(negedge clk);
    bus.start = 1'b1; bus.dividendo = 8'd100; bus.divisor = 8'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_listo", 32'(bus.listo), 32'd1);
    chk("midreset_valido", 32'(bus.valido), 32'd0);
    chk("midreset_cociente", 32'(bus.cociente), 32'd0);
    chk("midreset_residuo", 32'(bus.residuo), 32'd0);
    chk("midreset_div_cero", 32'(bus.div_cero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd77, 8'd5, lat);
    chk("post_reset_latency", 32'(lat), 32'd9);
    chk("post_reset_cociente", 32'(bus.cociente), 32'd15);
    chk("post_reset_residuo", 32'(bus.residuo), 32'd2);

    // Random pairs against a reference division.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (rb == 8'd0) begin
        eq = 8'hFF; er = ra;
      end else begin
        eq = ra / rb; er = ra % rb;
      end
      do_op(ra, rb, lat);
      chk($sformatf("rnd%0d_%0d/%0d_latency", i, ra, rb), 32'(lat), (rb == 8'd0) ? 32'd1 : 32'd9);
      chk($sformatf("rnd%0d_%0d/%0d_cociente", i, ra, rb), 32'(bus.cociente), 32'(eq));
      chk($sformatf("rnd%0d_%0d/%0d_residuo", i, ra, rb), 32'(bus.residuo), 32'(er));
      chk($sformatf("rnd%0d_%0d/%0d_div_cero", i, ra, rb), 32'(bus.div_cero), (rb == 8'd0) ? 32'd1 : 32'd0);
    end

    @(negedge clk);
    chk("protocol_violations", 32'(proto_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
